// File: rtl/preambula_pkg.sv
// Shared definitions for the preamble sync receiver: FSM encoding, the preamble
// geometry used by both the TX address counter and this RX detector, and the accumulator sizing.
package preambula_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      SKIP    = 2'd2,
      PASS    = 2'd3
   } state_t;

   localparam int PREAMB_LEN   = 107;
   localparam int PREAMB_DELAY = 16;
   localparam int PREAMB_WIN   = 16;

   // Moving sum of WIN full-precision complex products never overflows at this width.
   function automatic int acc_width(input int data_width, input int win);
      return 2 * data_width + 1 + $clog2(win);
   endfunction

endpackage

// File: rtl/preambula_autocorr.sv
// Delayed autocorrelation detector: P = sum r(n)conj(r(n-DELAY)), R = sum |r(n-DELAY)|^2
// over WIN samples. `above` is evaluated for the sample currently on the input.
module preambula_autocorr
   import preambula_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int DELAY        = 16,
   parameter int WIN          = 16,
   parameter int THRESH_SHIFT = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         en,
   input  logic                         clr,
   input  logic signed [DATA_WIDTH-1:0] in_i,
   input  logic signed [DATA_WIDTH-1:0] in_q,
   output logic                         above
);

   localparam int MW  = 2 * DATA_WIDTH;
   localparam int PW  = MW + 1;
   localparam int AW  = acc_width(DATA_WIDTH, WIN);
   localparam int AW1 = AW + 1;
   localparam int FW  = $clog2(DELAY + WIN + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(DELAY + WIN);

   logic signed [DATA_WIDTH-1:0] dl_i [DELAY];
   logic signed [DATA_WIDTH-1:0] dl_q [DELAY];
   logic signed [PW-1:0]         h_re [WIN];
   logic signed [PW-1:0]         h_im [WIN];
   logic signed [PW-1:0]         h_e  [WIN];
   logic signed [AW-1:0]         p_re, p_im, r_sum;
   logic signed [AW-1:0]         p_re_nx, p_im_nx, r_nx;
   logic signed [MW-1:0]         m_ii, m_qq, m_qi, m_iq, m_di, m_dq;
   logic signed [PW-1:0]         c_re, c_im, e_pw;
   logic        [AW:0]           mag, thr;
   logic        [FW-1:0]         fill;

   function automatic logic [AW:0] mag_of(input logic signed [AW-1:0] v);
      logic signed [AW:0] w;
      w = AW1'(v);
      return w[AW] ? -w : w;
   endfunction

   always_comb begin
      m_ii    = MW'(in_i) * MW'(dl_i[DELAY-1]);
      m_qq    = MW'(in_q) * MW'(dl_q[DELAY-1]);
      m_qi    = MW'(in_q) * MW'(dl_i[DELAY-1]);
      m_iq    = MW'(in_i) * MW'(dl_q[DELAY-1]);
      m_di    = MW'(dl_i[DELAY-1]) * MW'(dl_i[DELAY-1]);
      m_dq    = MW'(dl_q[DELAY-1]) * MW'(dl_q[DELAY-1]);
      c_re    = PW'(m_ii) + PW'(m_qq);
      c_im    = PW'(m_qi) - PW'(m_iq);
      e_pw    = PW'(m_di) + PW'(m_dq);
      p_re_nx = p_re  + AW'(c_re) - AW'(h_re[WIN-1]);
      p_im_nx = p_im  + AW'(c_im) - AW'(h_im[WIN-1]);
      r_nx    = r_sum + AW'(e_pw) - AW'(h_e[WIN-1]);
      mag     = mag_of(p_re_nx) + mag_of(p_im_nx);
      thr     = {1'b0, r_nx} >> THRESH_SHIFT;
      // Until the delay line and window are both full the metric is meaningless.
      above   = (fill == FILL_FULL) && (r_nx != '0) && (mag >= thr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || clr) begin
         for (int k = 0; k < DELAY; k++) begin
            dl_i[k] <= '0;
            dl_q[k] <= '0;
         end
         for (int k = 0; k < WIN; k++) begin
            h_re[k] <= '0;
            h_im[k] <= '0;
            h_e[k]  <= '0;
         end
         p_re  <= '0;
         p_im  <= '0;
         r_sum <= '0;
         fill  <= '0;
      end else if (en) begin
         dl_i[0] <= in_i;
         dl_q[0] <= in_q;
         for (int k = 1; k < DELAY; k++) begin
            dl_i[k] <= dl_i[k-1];
            dl_q[k] <= dl_q[k-1];
         end
         h_re[0] <= c_re;
         h_im[0] <= c_im;
         h_e[0]  <= e_pw;
         for (int k = 1; k < WIN; k++) begin
            h_re[k] <= h_re[k-1];
            h_im[k] <= h_im[k-1];
            h_e[k]  <= h_e[k-1];
         end
         p_re  <= p_re_nx;
         p_im  <= p_im_nx;
         r_sum <= r_nx;
         if (fill != FILL_FULL) fill <= fill + 1'b1;
      end
   end

endmodule

// File: rtl/preambula_sync.sv
// Receive preamble synchroniser: detects the periodic preamble, drops its tail and
// forwards one PAYLOAD_LEN-sample frame with a running index.
//
// state   | meaning
// SEARCH  | detector running, waiting for first above-threshold sample
// CONFIRM | counting consecutive above-threshold samples up to HOLD
// SKIP    | locked, discarding the remaining SKIP_LEN preamble samples
// PASS    | forwarding payload beats 0..PAYLOAD_LEN-1
module preambula_sync #(
   parameter int DATA_WIDTH   = 16,
   parameter int DELAY        = preambula_pkg::PREAMB_DELAY,
   parameter int WIN          = preambula_pkg::PREAMB_WIN,
   parameter int HOLD         = 4,
   parameter int PREAMB_LEN   = preambula_pkg::PREAMB_LEN,
   parameter int SKIP_LEN     = PREAMB_LEN - DELAY - WIN - HOLD,
   parameter int PAYLOAD_LEN  = 128,
   parameter int IDX_WIDTH    = 7,
   parameter int THRESH_SHIFT = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_i,
   input  logic signed [DATA_WIDTH-1:0] in_q,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_i,
   output logic signed [DATA_WIDTH-1:0] out_q,
   output logic        [IDX_WIDTH-1:0]  out_index,
   output logic                         frame_start,
   output logic                         lock
);
   import preambula_pkg::*;

   localparam int HW = $clog2(HOLD + 1);
   localparam int SW = $clog2(SKIP_LEN + 1);
   localparam int BW = IDX_WIDTH + 1;

   state_t          state, state_nx;
   logic            accept, above, det_en, det_clr, done;
   logic [HW-1:0]   hold_cnt;
   logic [SW-1:0]   skip_cnt;
   logic [BW-1:0]   beat_cnt;

   preambula_autocorr #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DELAY       (DELAY),
      .WIN         (WIN),
      .THRESH_SHIFT(THRESH_SHIFT)
   ) u_ac (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (det_en),
      .clr    (det_clr),
      .in_i   (in_i),
      .in_q   (in_q),
      .above  (above)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= SEARCH;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b1;
      lock     = 1'b0;
      det_en   = 1'b0;
      det_clr  = 1'b0;
      done     = 1'b0;
      case (state)
         SEARCH: begin
            det_en = in_valid;
            if (in_valid && above) state_nx = (HOLD <= 1) ? SKIP : CONFIRM;
         end
         CONFIRM: begin
            det_en = in_valid;
            if (in_valid) begin
               if (!above)                         state_nx = SEARCH;
               else if (hold_cnt == HW'(HOLD - 1)) state_nx = SKIP;
            end
         end
         SKIP: begin
            lock = 1'b1;
            if (in_valid && skip_cnt == SW'(SKIP_LEN - 1)) state_nx = PASS;
         end
         PASS: begin
            lock = 1'b1;
            // Once the whole frame is taken, hold the input off until the last beat drains.
            in_ready = (beat_cnt != BW'(PAYLOAD_LEN)) && (!out_valid || out_ready);
            done     = out_valid && out_ready && (out_index == IDX_WIDTH'(PAYLOAD_LEN - 1));
            det_clr  = done;
            if (done) state_nx = SEARCH;
         end
         default: state_nx = SEARCH;
      endcase
      accept      = in_valid && in_ready;
      frame_start = out_valid && (out_index == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt <= '0;
         skip_cnt <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            SEARCH:  hold_cnt <= HW'(1);
            CONFIRM: if (accept && above) hold_cnt <= hold_cnt + 1'b1;
            default: ;
         endcase
         skip_cnt <= (state != SKIP) ? '0 : skip_cnt + SW'(accept);
         beat_cnt <= (state != PASS) ? '0 : beat_cnt + BW'(accept);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_index <= '0;
      end else if (state == PASS && accept) begin
         out_valid <= 1'b1;
         out_i     <= in_i;
         out_q     <= in_q;
         out_index <= beat_cnt[IDX_WIDTH-1:0];
      end else begin
         if (out_ready) out_valid <= 1'b0;
         if (done)      out_index <= '0;
      end
   end

endmodule

// File: tb/tb_preambula_sync.sv
// Directed bench for preambula_sync: zero input, locked frames (continuous and gapped),
// output stall, short burst rejection and reset in the middle of a frame.
module tb_preambula_sync;
   import preambula_pkg::*;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_i = '0;
   logic signed [15:0] in_q = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_i, out_q;
   logic [6:0]         out_index;
   logic               frame_start;
   logic               lock;

   int n_chk = 0;
   int n_err = 0;
   int exp_idx = 0;
   int acc_cnt = 0;
   int lock_at = -1;
   bit lock_seen = 0;
   bit stall_en = 0;
   int stall_left = 0;
   bit rst_en = 0;
   bit aborted = 0;

   always #5 clk = ~clk;

   preambula_sync dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_i       (in_i),
      .in_q       (in_q),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_i      (out_i),
      .out_q      (out_q),
      .out_index  (out_index),
      .frame_start(frame_start),
      .lock       (lock)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pat_i(input int k);
      return (k - 7) * 1000 + 300;
   endfunction

   function automatic int pat_q(input int k);
      return (3 - k) * 700 + 100;
   endfunction

   function automatic int burst_i(input int n);
      case (n)
         16, 17, 18, 32, 33, 34: return 1000;
         19:                     return 3000;
         default:                return 0;
      endcase
   endfunction

   // Output side: drives out_ready, scores every transfer, plants stall and reset events.
   always @(negedge clk) begin
      if (reset_n) begin
         out_ready = 1'b1;
         if (rst_en && out_valid && out_index == 7'd60) begin
            #2 reset_n = 1'b0;
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_i", out_i, 0);
            chk("rst_out_q", out_q, 0);
            chk("rst_frame_start", frame_start, 0);
            chk("rst_lock", lock, 0);
            chk("rst_in_ready", in_ready, 1);
            aborted = 1;
            rst_en  = 0;
         end else begin
            if (stall_en && out_valid && out_index == 7'd40 && stall_left > 0) begin
               out_ready = 1'b0;
               #1;
               chk("stall_in_ready", in_ready, 0);
               chk("stall_index", out_index, 40);
               chk("stall_i", out_i, 40);
               chk("stall_q", out_q, -40);
               stall_left--;
            end
            if (out_valid && out_ready) begin
               chk("beat_index", out_index, exp_idx);
               chk("beat_i", out_i, exp_idx);
               chk("beat_q", out_q, -exp_idx);
               chk("beat_frame_start", frame_start, (exp_idx == 0) ? 1 : 0);
               exp_idx++;
            end
         end
      end
   end

   task automatic send(input int si, input int sq, input bit gap);
      int tries = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_i     = 16'(si);
      in_q     = 16'(sq);
      #1;
      while (!in_ready && tries < 50) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", in_ready, 1);
         return;
      end
      @(posedge clk);
      acc_cnt++;
      #1;
      if (lock && !lock_seen) begin
         lock_seen = 1;
         lock_at   = acc_cnt - 1;
      end
      if (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      exp_idx   = 0;
      acc_cnt   = 0;
      lock_seen = 0;
      lock_at   = -1;
      aborted   = 0;
   endtask

   task automatic run_stream(input bit gap);
      for (int k = 0; k < 107 && !aborted; k++) send(pat_i(k % 16), pat_q(k % 16), gap);
      for (int k = 0; k < 128 && !aborted; k++) send(k, -k, gap);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_frame(input string tag);
      int t = 0;
      while (exp_idx < 128 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_beats"}, exp_idx, 128);
      chk({tag, "_lock_at"}, lock_at, 35);
      chk({tag, "_lock_drop"}, lock, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_fsm"}, dut.state, SEARCH);
   endtask

   initial begin
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_i", out_i, 0);
      chk("reset_out_q", out_q, 0);
      chk("reset_out_index", out_index, 0);
      chk("reset_frame_start", frame_start, 0);
      chk("reset_lock", lock, 0);
      do_reset();

      for (int k = 0; k < 1000; k++) send(0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("zero_lock", lock_seen, 0);
      chk("zero_beats", exp_idx, 0);
      chk("zero_r_sum", dut.u_ac.r_sum, 0);

      do_reset();
      run_stream(0);
      finish_frame("cont");

      do_reset();
      run_stream(1);
      finish_frame("gap");

      do_reset();
      stall_en   = 1;
      stall_left = 5;
      run_stream(0);
      finish_frame("stall");
      chk("stall_done", stall_left, 0);
      stall_en = 0;

      do_reset();
      for (int n = 0; n < 36; n++) begin
         send(burst_i(n), 0, 0);
         if (n == 32) chk("burst_confirm_32", dut.state, CONFIRM);
         if (n == 34) chk("burst_confirm_34", dut.state, CONFIRM);
         if (n == 35) chk("burst_search_35", dut.state, SEARCH);
      end
      for (int n = 0; n < 100; n++) send(0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("burst_lock", lock_seen, 0);
      chk("burst_beats", exp_idx, 0);
      chk("burst_fsm", dut.state, SEARCH);

      do_reset();
      rst_en = 1;
      run_stream(0);
      chk("abort_seen", aborted, 1);
      chk("abort_beats", exp_idx, 60);
      do_reset();
      run_stream(0);
      finish_frame("after_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
